// File: rtl/serial_pkg.sv
// Shared state encoding and counter sizing for the serial pattern transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  localparam int GAP_CNT_W = 4;

  // Bit counter must index WIDTH positions; WIDTH is at least 2.
  function automatic int bit_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/pair_count.sv
// Counts adjacent equal-bit positions in a word: XNOR of neighbours, then popcount.
module pair_count
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(WIDTH)-1:0] pairs_o
);

  localparam int CNT_W = bit_cnt_w(WIDTH);

  logic [WIDTH-2:0] eq;

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_eq
    assign eq[gi] = ~(data_i[gi+1] ^ data_i[gi]);
  end

  always_comb begin
    pairs_o = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      pairs_o = pairs_o + CNT_W'(eq[i]);
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter with valid/ready word intake, post-word idle gap,
// end-of-word pulse and a registered count of adjacent equal bits.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     w,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] pairs
);

  localparam int                   BIT_CNT_W = bit_cnt_w(WIDTH);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST  = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  tx_state_e            state_q;
  logic [WIDTH-1:0]     shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [GAP_CNT_W-1:0] gap_cnt_q;
  logic                 done_q;
  logic [BIT_CNT_W-1:0] pairs_q;
  logic [BIT_CNT_W-1:0] pairs_d;

  pair_count #(
    .WIDTH(WIDTH)
  ) u_pair_count (
    .data_i (in_data),
    .pairs_o(pairs_d)
  );

  // Zeros shift in behind the word, so the register is empty again by the
  // time the last bit leaves and w reads 0 in GAP and IDLE with no extra gating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      pairs_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            shift_q   <= in_data;
            pairs_q   <= pairs_d;
            bit_cnt_q <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b1;
            state_q   <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign w        = shift_q[WIDTH-1];
  assign done     = done_q;
  assign pairs    = pairs_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two lanes (GAP=1 and GAP=0) checked every cycle
// against a timeline model, plus directed literal checks and a z-detector loop.
`timescale 1ns/1ps
module tb_serial_pattern_tx;

  localparam int W    = 8;
  localparam int PW   = $clog2(W);
  localparam int NL   = 2;
  localparam int RING = 64;
  localparam logic [W-1:0] LOW_MASK = {1'b0, {(W-1){1'b1}}};

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data  [NL];
  logic          in_valid [NL];
  logic          in_ready [NL];
  logic          w        [NL];
  logic          busy     [NL];
  logic          done     [NL];
  logic [PW-1:0] pairs    [NL];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Adjacent equal pairs = (W-1) minus the number of bit transitions.
  function automatic int ref_pairs(input logic [W-1:0] d);
    logic [W-1:0] t;
    t = (d ^ (d >> 1)) & LOW_MASK;
    return (W - 1) - $countones(t);
  endfunction

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int LGAP = (gi == 0) ? 1 : 0;

    serial_pattern_tx #(
      .WIDTH(W),
      .GAP  (LGAP)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .in_data (in_data[gi]),
      .in_valid(in_valid[gi]),
      .in_ready(in_ready[gi]),
      .w       (w[gi]),
      .busy    (busy[gi]),
      .done    (done[gi]),
      .pairs   (pairs[gi])
    );

    // Expected outputs per future cycle; slots default to the idle picture.
    bit exp_w      [RING];
    bit exp_busy   [RING];
    bit exp_done   [RING];
    bit exp_nready [RING];
    int exp_pairs;
    int cyc;
    int start_cyc;
    int zcnt;
    bit in_word;
    bit det_prev;
    bit det_z;

    initial begin
      cyc = 0; exp_pairs = 0; in_word = 0; det_prev = 0; det_z = 0;
      start_cyc = 0; zcnt = 0;
      for (int i = 0; i < RING; i++) begin
        exp_w[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; exp_nready[i] = 0;
      end
      forever begin
        @(negedge clk);
        if (!reset) begin
          for (int i = 0; i < RING; i++) begin
            exp_w[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; exp_nready[i] = 0;
          end
          exp_pairs = 0; in_word = 0; det_prev = 0; det_z = 0;
        end
        check($sformatf("lane%0d_w", gi),     int'(w[gi]),        int'(exp_w[cyc % RING]));
        check($sformatf("lane%0d_busy", gi),  int'(busy[gi]),     int'(exp_busy[cyc % RING]));
        check($sformatf("lane%0d_done", gi),  int'(done[gi]),     int'(exp_done[cyc % RING]));
        check($sformatf("lane%0d_ready", gi), int'(in_ready[gi]), int'(!exp_nready[cyc % RING]));
        check($sformatf("lane%0d_pairs", gi), int'(pairs[gi]),    exp_pairs);

        // Moore detector on w: z is high the cycle after two equal bits.
        if (in_word) begin
          if (cyc >= start_cyc + 2 && cyc <= start_cyc + W && det_z) zcnt++;
          if (cyc == start_cyc + W) begin
            check($sformatf("lane%0d_zloop", gi), zcnt, int'(pairs[gi]));
            in_word = 0;
          end
        end
        if (reset) begin
          det_z    = (w[gi] == det_prev);
          det_prev = w[gi];
        end

        exp_w[cyc % RING] = 0; exp_busy[cyc % RING] = 0;
        exp_done[cyc % RING] = 0;
        if (reset && in_valid[gi] && !exp_nready[cyc % RING]) begin
          for (int i = 0; i < W; i++) exp_w[(cyc + 1 + i) % RING] = in_data[gi][W-1-i];
          for (int i = 1; i <= W + LGAP; i++) begin
            exp_busy[(cyc + i) % RING]   = 1;
            exp_nready[(cyc + i) % RING] = 1;
          end
          exp_done[(cyc + 1 + W) % RING] = 1;
          exp_pairs = ref_pairs(in_data[gi]);
          start_cyc = cyc + 1; zcnt = 0; in_word = 1;
        end
        exp_nready[cyc % RING] = 0;
        cyc++;
      end
    end
  end

  // Returns at posedge+1 just after the handshake edge.
  task automatic wait_hs(input int l);
    bit ok;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready[l] && in_valid[l]) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    if (!ok) check("handshake_timeout", 0, 1);
  endtask

  task automatic capture_word(input int l, input logic [W-1:0] d, input string name);
    logic [W-1:0] cap;
    cap = '0;
    in_data[l] = d; in_valid[l] = 1'b1;
    wait_hs(l);
    in_valid[l] = 1'b0;
    for (int n = 1; n <= W; n++) begin
      @(negedge clk);
      cap = {cap[W-2:0], w[l]};
    end
    check(name, int'(cap), int'(d));
  endtask

  initial begin
    logic [W-1:0] cap;
    int done_at, ready_at, dcnt, per;
    bit got;

    for (int l = 0; l < NL; l++) begin
      in_valid[l] = 1'b0; in_data[l] = '0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;

    // 8'hA5 on the GAP=1 lane
    in_data[0] = 8'hA5; in_valid[0] = 1'b1;
    wait_hs(0);
    in_valid[0] = 1'b0;
    cap = '0; done_at = -1; ready_at = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= W) cap = {cap[W-2:0], w[0]};
      if (n == 1) check("A5_pairs", int'(pairs[0]), 1);
      if (done[0] && done_at < 0) done_at = n;
      if (in_ready[0] && ready_at < 0) ready_at = n;
    end
    check("A5_bits", int'(cap), 8'hA5);
    check("A5_done_cycle", done_at, 9);
    check("A5_ready_cycle", ready_at, 10);
    @(posedge clk); #1;

    // Back-to-back F0 then FF with in_valid held high
    in_data[0] = 8'hF0; in_valid[0] = 1'b1;
    wait_hs(0);
    in_data[0] = 8'hFF;
    got = 0; per = -1; dcnt = 0;
    for (int n = 1; n <= 30 && !got; n++) begin
      @(negedge clk);
      if (n == 1) check("F0_pairs", int'(pairs[0]), 6);
      if (done[0]) dcnt++;
      if (in_ready[0]) begin got = 1; per = n; end
    end
    check("b2b_period", per, 10);
    check("F0_done_count", dcnt, 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    dcnt = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) check("FF_pairs", int'(pairs[0]), 7);
      if (done[0]) dcnt++;
    end
    check("FF_done_count", dcnt, 1);
    @(posedge clk); #1;

    // 8'h55 twice on the GAP=0 lane
    in_data[1] = 8'h55; in_valid[1] = 1'b1;
    wait_hs(1);
    got = 0; per = -1;
    for (int n = 1; n <= 30 && !got; n++) begin
      @(negedge clk);
      if (n == 1) check("55_pairs", int'(pairs[1]), 0);
      if (n == W + 1) check("55_done_with_ready", int'(done[1] && in_ready[1] && !w[1]), 1);
      if (in_ready[1]) begin got = 1; per = n; end
    end
    check("55_period", per, 9);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk); #1;

    // Reset after bit 3 of 8'hC3
    in_data[0] = 8'hC3; in_valid[0] = 1'b1;
    wait_hs(0);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_w", int'(w[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_ready", int'(in_ready[0]), 1);
    check("rst_pairs", int'(pairs[0]), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done[0]) dcnt++;
    end
    check("rst_no_done", dcnt, 0);
    @(posedge clk); #1;
    capture_word(0, 8'hC3, "C3_after_reset");
    repeat (4) @(negedge clk);
    @(posedge clk); #1;

    // Randomized traffic on both lanes
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < NL; l++) begin
        in_valid[l] = ($urandom_range(0, 2) != 0);
        in_data[l]  = W'($urandom);
      end
      @(posedge clk); #1;
    end
    for (int l = 0; l < NL; l++) in_valid[l] = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
